axi4_ram_subsystem: RTL and testbench
=====================================

Name:
axi4_ram_subsystem

Overview:
- Self-contained AXI4 slave word memory. It is the target that the system's AXI4 master drives, and is clocked by the system clock/reset pair.
- Accepts single-beat and INCR burst writes with byte strobes, and single-beat and INCR burst reads.
- One write transaction and one read transaction may be in progress at a time. The read and write channels operate independently.

Parameters:
- ADDR_WIDTH, 16: byte-address width.
- DATA_WIDTH, 32: data bus width; must be 32, 64 or 128.
- ID_WIDTH, 18: AXI ID width.

Ports:
clk_clk  in  1  system clock; all logic on rising edge
reset_reset  in  1  synchronous, active-high reset
s_awid  in  ID_WIDTH  write ID
s_awaddr  in  ADDR_WIDTH  write start byte address
s_awlen  in  8  write beats minus 1
s_awvalid  in  1  write address valid
s_awready  out  1  write address ready
s_wdata  in  DATA_WIDTH  write data
s_wstrb  in  DATA_WIDTH/8  byte-lane enables
s_wlast  in  1  final write beat
s_wvalid  in  1  write data valid
s_wready  out  1  write data ready
s_bid  out  ID_WIDTH  response ID (= accepted AWID)
s_bresp  out  2  write response
s_bvalid  out  1  write response valid
s_bready  in  1  write response ready
s_arid  in  ID_WIDTH  read ID
s_araddr  in  ADDR_WIDTH  read start byte address
s_arlen  in  8  read beats minus 1
s_arvalid  in  1  read address valid
s_arready  out  1  read address ready
s_rid  out  ID_WIDTH  read ID (= accepted ARID)
s_rdata  out  DATA_WIDTH  read data
s_rresp  out  2  read response, always 2'b00
s_rlast  out  1  final read beat
s_rvalid  out  1  read data valid
s_rready  in  1  read data ready

Behaviour:
- **Memory**
  - 2^ADDR_WIDTH bytes, organised as DATA_WIDTH-bit words.
  - Word index = addr >> log2(DATA_WIDTH/8). Low address bits are ignored.
  - Contents are not reset and survive reset.
- **Burst type and size**
  - Every burst is full-width INCR; no AxSIZE/AxBURST ports exist.
  - The word index increments by 1 per beat and wraps modulo the memory size.
  - Bursts are 1 to 256 beats.
- **Reset**
  - While reset_reset=1: s_awready, s_arready, s_wready, s_bvalid, s_rvalid, s_rlast = 0; s_bresp, s_rresp, s_bid, s_rid, s_rdata = 0.
  - The first cycle after reset deasserts: s_awready=1 and s_arready=1.
  - Reset mid-transaction aborts it; beats already written stay in memory.
- **Write FSM: W_IDLE -> W_DATA -> W_RESP -> W_IDLE**
  - W_IDLE: s_awready=1. On AW handshake, latch ID, word index and beat count, then go to W_DATA; s_awready drops.
  - W_DATA: s_wready=1. Each W handshake writes only the byte lanes whose strobe bit is 1 at that clock edge, then increments the index.
    - After AWLEN+1 beats go to W_RESP, whatever the state of WLAST.
    - s_bresp=2'b10 (SLVERR) if s_wlast is 0 on the last counted beat or 1 on an earlier beat; otherwise 2'b00.
    - The data is written in both cases.
  - W_RESP: s_bvalid=1 with s_bid=latched ID, held until s_bready.
    - The B handshake returns the FSM to W_IDLE, where s_awready=1 on the next cycle.
  - W data presented before the AW handshake is not accepted.
- **Read FSM: R_IDLE -> R_DATA -> R_IDLE**
  - R_IDLE: s_arready=1. On AR handshake at edge N:
    - s_rdata loads mem[index] and s_rvalid=1 from cycle N+1, i.e. 1-cycle latency.
    - s_rid=ARID; s_rlast=1 if ARLEN=0.
  - R_DATA, beats not last: on each R handshake, s_rdata loads the next word at the same edge, so beats can run back-to-back with no bubbles.
  - While s_rready=0, s_rdata, s_rlast and s_rvalid hold stable.
  - The handshake on the s_rlast beat clears s_rvalid and returns the FSM to R_IDLE.
- **Collisions**
  - A read and a write to the same word at the same edge return the old data. The write takes effect after that edge.
  - Simultaneous AW and AR handshakes are both accepted.
- **Implementation constraints**
  - No combinational path from any input to any output.
  - All outputs are registered or decoded from FSM state.

Test Plan:
1. Single write AWADDR=0x0000, data 0x01010101, WSTRB=4'hF, then AWADDR=0x0004, data 0x02020202 -> each returns BVALID with BRESP=0, BID=0. Single reads of 0x0000 and 0x0004 -> 0x01010101 and 0x02020202, RLAST=1, RVALID 1 cycle after AR handshake.
2. Write burst AWADDR=0, AWLEN=7, data 0..7, full strobes, WLAST on beat 8 -> one BRESP=0. Read burst ARADDR=0, ARLEN=7 with RREADY held at 1 -> 8 consecutive beats 0..7, RLAST only on beat 8.
3. Write 0xAABBCCDD to 0x0010, then write 0x11223344 with WSTRB=4'b0101 -> read returns 0xAA22CC44.
4. Read burst of 4 with RREADY toggled 1,0,0,1,... -> data and RLAST held during stalls, values still in order, no beat lost.
5. Write burst AWLEN=3 with WLAST asserted on beat 2 -> 4 beats accepted, BRESP=2'b10. Assert reset while in W_DATA -> all valid/ready outputs 0 next cycle, s_awready=1 after release, prior written data still readable.
6. Burst write starting at word index 2^ADDR_WIDTH/(DATA_WIDTH/8)-1, AWLEN=1 -> beat 2 lands at word 0, read back identical.

Source files
------------

// File: rtl/axi4_ram_subsystem.sv
// AXI4 slave word memory: INCR bursts with byte strobes, one write and one read
// transaction in flight at a time on independent channels.
module axi4_ram_subsystem #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 18
) (
    input  logic                    clk_clk,
    input  logic                    reset_reset,
    input  logic [ID_WIDTH-1:0]     s_awid,
    input  logic [ADDR_WIDTH-1:0]   s_awaddr,
    input  logic [7:0]              s_awlen,
    input  logic                    s_awvalid,
    output logic                    s_awready,
    input  logic [DATA_WIDTH-1:0]   s_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_wstrb,
    input  logic                    s_wlast,
    input  logic                    s_wvalid,
    output logic                    s_wready,
    output logic [ID_WIDTH-1:0]     s_bid,
    output logic [1:0]              s_bresp,
    output logic                    s_bvalid,
    input  logic                    s_bready,
    input  logic [ID_WIDTH-1:0]     s_arid,
    input  logic [ADDR_WIDTH-1:0]   s_araddr,
    input  logic [7:0]              s_arlen,
    input  logic                    s_arvalid,
    output logic                    s_arready,
    output logic [ID_WIDTH-1:0]     s_rid,
    output logic [DATA_WIDTH-1:0]   s_rdata,
    output logic [1:0]              s_rresp,
    output logic                    s_rlast,
    output logic                    s_rvalid,
    input  logic                    s_rready
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int IDX_W  = ADDR_WIDTH - OFF_W;
    localparam int DEPTH  = 2 ** IDX_W;

    // The *_RST states hold every ready/valid low while reset is asserted
    // without routing reset_reset combinationally to the outputs.
    typedef enum logic [1:0] {W_RST, W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_RST, R_IDLE, R_DATA} r_state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    w_state_t              w_state, w_state_nxt;
    r_state_t              r_state, r_state_nxt;
    logic [IDX_W-1:0]      w_idx, r_idx, aw_idx, ar_idx;
    logic [7:0]            w_cnt, r_cnt;
    logic                  w_err, beat_err;
    logic [ID_WIDTH-1:0]   bid_q, rid_q;
    logic [1:0]            bresp_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  rlast_q;
    logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic                  unused_addr_bits;

    assign aw_idx = s_awaddr[ADDR_WIDTH-1:OFF_W];
    assign ar_idx = s_araddr[ADDR_WIDTH-1:OFF_W];
    assign unused_addr_bits = ^{s_awaddr[OFF_W-1:0], s_araddr[OFF_W-1:0]};

    assign aw_hs = s_awvalid & s_awready;
    assign w_hs  = s_wvalid  & s_wready;
    assign b_hs  = s_bvalid  & s_bready;
    assign ar_hs = s_arvalid & s_arready;
    assign r_hs  = s_rvalid  & s_rready;

    // A beat is in error if WLAST disagrees with the beat count.
    assign beat_err = (w_cnt == '0) ? ~s_wlast : s_wlast;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            w_state <= W_RST;
            r_state <= R_RST;
        end else begin
            w_state <= w_state_nxt;
            r_state <= r_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = w_state;
        case (w_state)
            W_RST:   w_state_nxt = W_IDLE;
            W_IDLE:  if (aw_hs) w_state_nxt = W_DATA;
            W_DATA:  if (w_hs && w_cnt == '0) w_state_nxt = W_RESP;
            W_RESP:  if (b_hs) w_state_nxt = W_IDLE;
            default: w_state_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_nxt = r_state;
        case (r_state)
            R_RST:   r_state_nxt = R_IDLE;
            R_IDLE:  if (ar_hs) r_state_nxt = R_DATA;
            R_DATA:  if (r_hs && rlast_q) r_state_nxt = R_IDLE;
            default: r_state_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        s_awready = 1'b0;
        s_wready  = 1'b0;
        s_bvalid  = 1'b0;
        s_arready = 1'b0;
        s_rvalid  = 1'b0;
        case (w_state)
            W_IDLE:  s_awready = 1'b1;
            W_DATA:  s_wready  = 1'b1;
            W_RESP:  s_bvalid  = 1'b1;
            default: ;
        endcase
        case (r_state)
            R_IDLE:  s_arready = 1'b1;
            R_DATA:  s_rvalid  = 1'b1;
            default: ;
        endcase
    end

    assign s_bid   = bid_q;
    assign s_bresp = bresp_q;
    assign s_rid   = rid_q;
    assign s_rdata = rdata_q;
    assign s_rlast = rlast_q;
    assign s_rresp = 2'b00;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            w_idx   <= '0;
            w_cnt   <= '0;
            w_err   <= 1'b0;
            bid_q   <= '0;
            bresp_q <= '0;
        end else begin
            if (aw_hs) begin
                bid_q <= s_awid;
                w_idx <= aw_idx;
                w_cnt <= s_awlen;
                w_err <= 1'b0;
            end
            if (w_hs) begin
                w_idx <= w_idx + IDX_W'(1);
                w_cnt <= w_cnt - 8'd1;
                w_err <= w_err | beat_err;
                if (w_cnt == '0) begin
                    bresp_q <= (w_err | beat_err) ? 2'b10 : 2'b00;
                end
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset && w_hs) begin
            for (int unsigned b = 0; b < STRB_W; b++) begin
                if (s_wstrb[b]) begin
                    mem[w_idx][8*b +: 8] <= s_wdata[8*b +: 8];
                end
            end
        end
    end

    // r_idx points at the word to present on the next accepted beat; r_cnt
    // counts beats remaining after the one currently presented.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_idx   <= '0;
            r_cnt   <= '0;
            rid_q   <= '0;
            rdata_q <= '0;
            rlast_q <= 1'b0;
        end else if (ar_hs) begin
            rid_q   <= s_arid;
            rdata_q <= mem[ar_idx];
            r_idx   <= ar_idx + IDX_W'(1);
            r_cnt   <= s_arlen;
            rlast_q <= (s_arlen == '0);
        end else if (r_hs) begin
            if (rlast_q) begin
                rlast_q <= 1'b0;
            end else begin
                rdata_q <= mem[r_idx];
                r_idx   <= r_idx + IDX_W'(1);
                r_cnt   <= r_cnt - 8'd1;
                rlast_q <= (r_cnt == 8'd1);
            end
        end
    end

endmodule

// File: tb/tb_axi4_ram_subsystem.sv
// Directed bench for axi4_ram_subsystem with a byte-lane memory model and
// queued expected read data / write responses.
module tb_axi4_ram_subsystem;

    localparam int AW    = 16;
    localparam int DW    = 32;
    localparam int IW    = 18;
    localparam int SW    = DW / 8;
    localparam int OFF   = 2;
    localparam int DEPTH = 2 ** (AW - OFF);

    logic          clk_clk = 1'b0;
    logic          reset_reset = 1'b1;
    logic [IW-1:0] s_awid = '0;
    logic [AW-1:0] s_awaddr = '0;
    logic [7:0]    s_awlen = '0;
    logic          s_awvalid = 1'b0;
    logic          s_awready;
    logic [DW-1:0] s_wdata = '0;
    logic [SW-1:0] s_wstrb = '0;
    logic          s_wlast = 1'b0;
    logic          s_wvalid = 1'b0;
    logic          s_wready;
    logic [IW-1:0] s_bid;
    logic [1:0]    s_bresp;
    logic          s_bvalid;
    logic          s_bready = 1'b0;
    logic [IW-1:0] s_arid = '0;
    logic [AW-1:0] s_araddr = '0;
    logic [7:0]    s_arlen = '0;
    logic          s_arvalid = 1'b0;
    logic          s_arready;
    logic [IW-1:0] s_rid;
    logic [DW-1:0] s_rdata;
    logic [1:0]    s_rresp;
    logic          s_rlast;
    logic          s_rvalid;
    logic          s_rready = 1'b0;

    always #5 clk_clk = ~clk_clk;

    axi4_ram_subsystem #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
        .clk_clk(clk_clk), .reset_reset(reset_reset),
        .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen),
        .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
        .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen),
        .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_rvalid(s_rvalid), .s_rready(s_rready)
    );

    logic [DW-1:0]   model [DEPTH];
    logic [DW-1:0]   rd_q [$];
    logic [IW+1:0]   b_q [$];
    int              n_checks = 0;
    int              n_fail = 0;

    task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_write(input int idx, input logic [DW-1:0] d, input logic [SW-1:0] strb);
        for (int b = 0; b < SW; b++)
            if (strb[b]) model[idx % DEPTH][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic check_all_zero(input string tag);
        chk({s_awready, s_arready, s_wready, s_bvalid, s_rvalid, s_rlast}, '0, {tag, "_flags"});
        chk({s_bresp, s_rresp}, '0, {tag, "_resp"});
        chk({s_bid, s_rid}, '0, {tag, "_ids"});
        chk(s_rdata, '0, {tag, "_rdata"});
    endtask

    task automatic axi_write(input logic [AW-1:0] addr, input logic [7:0] len,
                             input logic [DW-1:0] base, input logic [SW-1:0] strb,
                             input int wlast_at, input logic [IW-1:0] id,
                             input logic [1:0] exp_resp, input string tag);
        int cyc;
        logic [IW+1:0] exp_b;
        b_q.push_back({id, exp_resp});
        s_awid = id; s_awaddr = addr; s_awlen = len; s_awvalid = 1'b1;
        cyc = 0;
        while (s_awready !== 1'b1 && cyc < 50) begin @(negedge clk_clk); cyc++; end
        chk(s_awready, 1, {tag, "_awready"});
        @(negedge clk_clk);
        s_awvalid = 1'b0;
        chk(s_awready, 0, {tag, "_awready_drop"});
        for (int i = 0; i <= int'(len); i++) begin
            s_wdata  = base + DW'(i);
            s_wstrb  = strb;
            s_wlast  = (wlast_at < 0) ? (i == int'(len)) : (i == wlast_at);
            s_wvalid = 1'b1;
            cyc = 0;
            while (s_wready !== 1'b1 && cyc < 50) begin @(negedge clk_clk); cyc++; end
            chk(s_wready, 1, {tag, "_wready"});
            model_write(int'(addr >> OFF) + i, s_wdata, strb);
            @(negedge clk_clk);
        end
        s_wvalid = 1'b0; s_wlast = 1'b0; s_bready = 1'b1;
        chk(s_bvalid, 1, {tag, "_bvalid"});
        exp_b = b_q.pop_front();
        chk(s_bresp, exp_b[1:0], {tag, "_bresp"});
        chk(s_bid, exp_b[IW+1:2], {tag, "_bid"});
        @(negedge clk_clk);
        s_bready = 1'b0;
        chk(s_bvalid, 0, {tag, "_bvalid_clr"});
        chk(s_awready, 1, {tag, "_awready_back"});
    endtask

    task automatic axi_read(input logic [AW-1:0] addr, input logic [7:0] len,
                            input logic [IW-1:0] id, input bit stall, input string tag);
        int cyc, left;
        for (int i = 0; i <= int'(len); i++)
            rd_q.push_back(model[(int'(addr >> OFF) + i) % DEPTH]);
        s_arid = id; s_araddr = addr; s_arlen = len; s_arvalid = 1'b1;
        cyc = 0;
        while (s_arready !== 1'b1 && cyc < 50) begin @(negedge clk_clk); cyc++; end
        chk(s_arready, 1, {tag, "_arready"});
        @(negedge clk_clk);
        s_arvalid = 1'b0;
        chk(s_rvalid, 1, {tag, "_rvalid_latency"});
        chk(s_rid, id, {tag, "_rid"});
        left = int'(len) + 1;
        cyc = 0;
        while (left > 0 && cyc < 2000) begin
            s_rready = stall ? (cyc % 3 == 0) : 1'b1;
            chk(s_rvalid, 1, {tag, "_rvalid"});
            chk(s_rdata, rd_q[0], {tag, "_rdata"});
            chk(s_rlast, (left == 1), {tag, "_rlast"});
            chk(s_rresp, 0, {tag, "_rresp"});
            if (s_rready && s_rvalid === 1'b1) begin
                void'(rd_q.pop_front());
                left--;
            end
            @(negedge clk_clk);
            cyc++;
        end
        s_rready = 1'b0;
        chk(left, 0, {tag, "_beats_left"});
        chk(s_rvalid, 0, {tag, "_rvalid_clr"});
        chk(s_arready, 1, {tag, "_arready_back"});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk_clk);
        check_all_zero("reset");
        reset_reset = 1'b0;
        @(negedge clk_clk);
        chk(s_awready, 1, "post_reset_awready");
        chk(s_arready, 1, "post_reset_arready");

        // 1: single beats
        axi_write(16'h0000, 8'd0, 32'h01010101, 4'hF, -1, '0, 2'b00, "t1_w0");
        axi_write(16'h0004, 8'd0, 32'h02020202, 4'hF, -1, '0, 2'b00, "t1_w1");
        axi_read(16'h0000, 8'd0, 18'h00005, 1'b0, "t1_r0");
        axi_read(16'h0004, 8'd0, 18'h3FFFF, 1'b0, "t1_r1");

        // 2: 8-beat bursts
        axi_write(16'h0000, 8'd7, 32'h0, 4'hF, -1, 18'h2A5A5, 2'b00, "t2_w");
        axi_read(16'h0000, 8'd7, 18'h15A5A, 1'b0, "t2_r");

        // 3: partial strobes
        axi_write(16'h0010, 8'd0, 32'hAABBCCDD, 4'hF, -1, 18'h1, 2'b00, "t3_w0");
        axi_write(16'h0010, 8'd0, 32'h11223344, 4'b0101, -1, 18'h2, 2'b00, "t3_w1");
        axi_read(16'h0010, 8'd0, 18'h3, 1'b0, "t3_r");

        // 4: stalled read burst
        axi_read(16'h0000, 8'd3, 18'h4, 1'b1, "t4_r");

        // 5: early WLAST -> SLVERR, then reset inside W_DATA
        axi_write(16'h0100, 8'd3, 32'h50, 4'hF, 1, 18'h6, 2'b10, "t5_w");
        s_awid = 18'h7; s_awaddr = 16'h0200; s_awlen = 8'd3; s_awvalid = 1'b1;
        @(negedge clk_clk);
        s_awvalid = 1'b0;
        s_wdata = 32'hDEADBEEF; s_wstrb = 4'hF; s_wlast = 1'b0; s_wvalid = 1'b1;
        chk(s_wready, 1, "t5_rst_wready");
        model_write(16'h0200 >> OFF, s_wdata, s_wstrb);
        @(negedge clk_clk);
        s_wvalid = 1'b0;
        chk(s_wready, 1, "t5_in_wdata");
        reset_reset = 1'b1;
        @(negedge clk_clk);
        check_all_zero("t5_mid_reset");
        reset_reset = 1'b0;
        @(negedge clk_clk);
        chk(s_awready, 1, "t5_awready_after");
        chk(s_wready, 0, "t5_wready_after");
        axi_read(16'h0200, 8'd0, 18'h8, 1'b0, "t5_r_partial");
        axi_read(16'h0100, 8'd3, 18'h9, 1'b0, "t5_r_err_burst");

        // 6: wrap from the top word to word 0
        axi_write(16'hFFFC, 8'd1, 32'h77770000, 4'hF, -1, 18'hA, 2'b00, "t6_w");
        axi_read(16'hFFFC, 8'd1, 18'hB, 1'b0, "t6_r");
        axi_read(16'h0000, 8'd0, 18'hC, 1'b0, "t6_r_word0");

        // Read and write to the same word at the same edge returns old data
        axi_write(16'h0020, 8'd0, 32'h12345678, 4'hF, -1, 18'hD, 2'b00, "col_init");
        s_awid = 18'hE; s_awaddr = 16'h0020; s_awlen = 8'd0; s_awvalid = 1'b1;
        b_q.push_back({18'hE, 2'b00});
        @(negedge clk_clk);
        s_awvalid = 1'b0;
        s_wdata = 32'hCAFEF00D; s_wstrb = 4'hF; s_wlast = 1'b1; s_wvalid = 1'b1;
        s_arid = 18'hF; s_araddr = 16'h0020; s_arlen = 8'd0; s_arvalid = 1'b1;
        rd_q.push_back(model[16'h0020 >> OFF]);
        chk({s_wready, s_arready}, 2'b11, "col_ready");
        @(negedge clk_clk);
        model_write(16'h0020 >> OFF, s_wdata, s_wstrb);
        s_wvalid = 1'b0; s_wlast = 1'b0; s_arvalid = 1'b0;
        chk(s_rvalid, 1, "col_rvalid");
        chk(s_rdata, rd_q.pop_front(), "col_old_data");
        chk(s_bvalid, 1, "col_bvalid");
        chk({s_bid, s_bresp}, b_q.pop_front(), "col_b");
        s_rready = 1'b1; s_bready = 1'b1;
        @(negedge clk_clk);
        s_rready = 1'b0; s_bready = 1'b0;
        chk({s_rvalid, s_bvalid}, 2'b00, "col_clear");
        axi_read(16'h0020, 8'd0, 18'h10, 1'b0, "col_new_data");

        // Simultaneous AW and AR handshakes
        s_awid = 18'h11; s_awaddr = 16'h0024; s_awlen = 8'd0; s_awvalid = 1'b1;
        s_arid = 18'h12; s_araddr = 16'h0004; s_arlen = 8'd0; s_arvalid = 1'b1;
        rd_q.push_back(model[1]);
        @(negedge clk_clk);
        s_awvalid = 1'b0; s_arvalid = 1'b0;
        chk({s_awready, s_arready}, 2'b00, "sim_both_taken");
        chk(s_rdata, rd_q.pop_front(), "sim_rdata");
        chk(s_rid, 18'h12, "sim_rid");
        s_rready = 1'b1;
        s_wdata = 32'h0BADCAFE; s_wstrb = 4'hF; s_wlast = 1'b1; s_wvalid = 1'b1;
        model_write(16'h0024 >> OFF, s_wdata, s_wstrb);
        @(negedge clk_clk);
        s_rready = 1'b0; s_wvalid = 1'b0; s_wlast = 1'b0; s_bready = 1'b1;
        chk(s_bvalid, 1, "sim_bvalid");
        chk(s_bid, 18'h11, "sim_bid");
        @(negedge clk_clk);
        s_bready = 1'b0;
        axi_read(16'h0024, 8'd0, 18'h13, 1'b0, "sim_readback");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
